keypad_scanner: RTL
===================

# keypad_scanner

- Drives the column lines of the 4x4 sale-terminal keypad with a rotating one-hot strobe and samples the row lines.
- Debounces whole-keypad frames and presents the stable key as a 16-bit one-hot vector. This vector is the input format of the terminal's 16-to-4 key encoder.
- Adds a one-cycle `key_strobe` on each newly accepted key, for the sale-entry logic.

## Interface

Parameters:
- `SCAN_DIV`, default 1000: clock cycles each column is driven (dwell). Must be ≥ 4.
- `DEBOUNCE_SCANS`, default 4: number of consecutive identical frames required to commit. Must be ≥ 2.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `row_in`  in  4  keypad rows, asynchronous to `clk`; a row reads 1 when a pressed key connects it to the driven column.
- `col_out`  out  4  one-hot, active-high column drive.
- `key_onehot`  out  16  committed key; bit index = col*4 + row; zero when no valid key.
- `key_valid`  out  1  high while `key_onehot` holds exactly one set bit.
- `key_strobe`  out  1  one-cycle pulse when a new valid key is committed.

## Operation

Row synchronizer:
- `row_in` passes through a 2-flop synchronizer (`row_s`).

Column scan:
- Dwell counter `div` counts 0..SCAN_DIV-1 and wraps.
- Column index `col` is 2 bits; `col_out` = 1 << `col`.
- On the edge where `div` == SCAN_DIV-1:
  - `row_s` is written into `frame[col*4 +: 4]`.
  - `col` increments, wrapping 3 → 0.

Frame evaluation (on the edge where column 3 is sampled, using the complete new frame `F`):
- `match_cnt`:
  - if `F` == `last_frame`: `match_cnt` = min(`match_cnt`+1, DEBOUNCE_SCANS);
  - otherwise: `match_cnt` = 1.
- `last_frame` ← `F`.
- Commit happens when `match_cnt` reaches DEBOUNCE_SCANS on this evaluation (transition only). It does not repeat while saturated.

Commit rules:
- popcount(F) == 1: `key_onehot` ← F, `key_valid` ← 1.
- popcount(F) == 0 (release), or popcount(F) ≥ 2 (multi-key/ghost rejection): `key_onehot` ← 0, `key_valid` ← 0.

Strobe state machine, states RELEASED and HELD:
- RELEASED → HELD on a valid commit; `key_strobe` pulses.
- HELD → HELD on a valid commit whose value differs from the current `key_onehot` (direct key change); `key_strobe` pulses.
- HELD → RELEASED on an invalid commit (zero or multi-key); no pulse.
- A same-value commit cannot occur while saturated. If it does occur after a bounce, no pulse is issued.

## Timing

Reset values (applied asynchronously on `rst`):
- `col_out` = 4'b0001; `col`, `div`, `frame`, `last_frame`, `match_cnt` = 0; state RELEASED.
- `key_onehot` = 16'h0000; `key_valid` = 0; `key_strobe` = 0.

Scan timing:
- Column dwell is SCAN_DIV cycles; a frame is 4·SCAN_DIV cycles.
- `col_out` changes on the same edge that samples the outgoing column.
- Rows are sampled SCAN_DIV-1 cycles after a column is asserted. This covers line settling plus the 2-cycle synchronizer latency.

Commit timing:
- `key_onehot`, `key_valid` and `key_strobe` are registered and update on the edge after frame evaluation (1 cycle).
- `key_strobe` is high for exactly 1 cycle.
- Press stable from a frame boundary to strobe: DEBOUNCE_SCANS frames + 1 cycle. A press arriving mid-frame adds up to one frame.

Boundary cases:
- Reset mid-dwell or mid-frame: everything returns to reset values immediately, including `col_out` = 0001. Scanning restarts from column 0 with `div` = 0 after release.
- Any frame differing from the previous one restarts debounce at `match_cnt` = 1. Committed outputs hold their prior values until the next commit.

## Test plan

All scenarios use SCAN_DIV = 4 and DEBOUNCE_SCANS = 2 (frame = 16 cycles).

1. **Reset and scan:** assert `rst`, then release.
   - During reset: `col_out` = 0001, all outputs 0.
   - `col_out` sequence is 0001 → 0010 → 0100 → 1000, 4 cycles each, back to 0001 after 16 cycles.
2. **Single key (key 6):** drive `row_in[2]` = 1 only while `col_out` == 0010, starting at a frame boundary.
   - After the 2nd identical frame + 1 cycle: `key_onehot` = 16'h0040, `key_valid` = 1.
   - `key_strobe` pulses once; no further pulses while held for 10 frames.
3. **Bounce:** alternate key 6 present/absent on successive frames for 6 frames.
   - No commit, `key_strobe` never asserts, `key_onehot` stays 0.
   - Then hold key 6 steady: commit follows per scenario 2.
4. **Multi-key:** press key 0 and key 5 together.
   - `key_onehot` = 0, `key_valid` = 0, no strobe.
   - Then drop key 5 (key 0 alone): `key_onehot` = 16'h0001 with one strobe.
5. **Release and change:**
   - Key 6 held then released: `key_onehot` → 0, no strobe.
   - Key 6 pressed again: strobe, `key_onehot` = 16'h0040.
   - Switch directly to key 15 (16'h8000) with no release frame: one strobe.
6. **Reset mid-operation:** assert `rst` mid-dwell of column 2 while key 6 is committed.
   - Same cycle: `key_onehot` = 0, `key_valid` = 0, `col_out` = 0001.
   - After release with key still held: strobe re-fires after 2 frames + 1 cycle.

Source files
------------

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with frame debounce and one-hot key output
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [15:0] key_onehot,
    output logic        key_valid,
    output logic        key_strobe
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {ST_RELEASED, ST_HELD} state_t;

    logic [3:0]       r_row_meta;
    logic [3:0]       r_row_s;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_col;
    logic [15:0]      r_frame;
    logic [15:0]      r_last_frame;
    logic [CNT_W-1:0] r_match_cnt;
    logic             r_commit;
    logic [15:0]      r_commit_frame;
    state_t           r_state;
    logic [15:0]      r_key_onehot;
    logic             r_key_valid;
    logic             r_key_strobe;

    logic             w_sample;
    logic             w_eval;
    logic [15:0]      w_frame_new;
    logic             w_same;
    logic [CNT_W-1:0] w_match_next;
    logic             w_commit;
    logic             w_single;
    state_t           w_state_next;
    logic [15:0]      w_onehot_next;
    logic             w_valid_next;
    logic             w_strobe_next;

    assign w_sample = (r_div == DIV_LAST);
    assign w_eval   = w_sample && (r_col == 2'd3);

    always_comb begin
        w_frame_new = r_frame;
        w_frame_new[{r_col, 2'b00} +: 4] = r_row_s;
    end

    assign w_same       = (w_frame_new == r_last_frame);
    assign w_match_next = !w_same ? CNT_ONE :
                          (r_match_cnt == CNT_MAX) ? CNT_MAX : r_match_cnt + CNT_ONE;
    // Commit only on the transition into saturation, never while already saturated.
    assign w_commit     = w_eval && w_same && (r_match_cnt == CNT_MAX - CNT_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_meta     <= 4'd0;
            r_row_s        <= 4'd0;
            r_div          <= '0;
            r_col          <= 2'd0;
            r_frame        <= 16'd0;
            r_last_frame   <= 16'd0;
            r_match_cnt    <= '0;
            r_commit       <= 1'b0;
            r_commit_frame <= 16'd0;
        end else begin
            r_row_meta <= row_in;
            r_row_s    <= r_row_meta;
            r_commit   <= w_commit;
            if (w_sample) begin
                r_div   <= '0;
                r_col   <= r_col + 2'd1;
                r_frame <= w_frame_new;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
            if (w_eval) begin
                r_last_frame   <= w_frame_new;
                r_match_cnt    <= w_match_next;
                r_commit_frame <= w_frame_new;
            end
        end
    end

    assign w_single = (r_commit_frame != 16'd0) &&
                      ((r_commit_frame & (r_commit_frame - 16'd1)) == 16'd0);

    always_comb begin
        w_state_next  = r_state;
        w_onehot_next = r_key_onehot;
        w_valid_next  = r_key_valid;
        w_strobe_next = 1'b0;
        if (r_commit) begin
            if (w_single) begin
                w_state_next  = ST_HELD;
                w_onehot_next = r_commit_frame;
                w_valid_next  = 1'b1;
                w_strobe_next = (r_state == ST_RELEASED) || (r_commit_frame != r_key_onehot);
            end else begin
                w_state_next  = ST_RELEASED;
                w_onehot_next = 16'd0;
                w_valid_next  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RELEASED;
            r_key_onehot <= 16'd0;
            r_key_valid  <= 1'b0;
            r_key_strobe <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_key_onehot <= w_onehot_next;
            r_key_valid  <= w_valid_next;
            r_key_strobe <= w_strobe_next;
        end
    end

    assign col_out    = 4'b0001 << r_col;
    assign key_onehot = r_key_onehot;
    assign key_valid  = r_key_valid;
    assign key_strobe = r_key_strobe;

endmodule
